hwpe_ctrl_uloop_stream: RTL and testbench
=========================================

// Module: hwpe_ctrl_uloop_stream
// PURPOSE
// Parametrised nested-loop offset generator for HWPE streamers. It walks NB_LOOPS nested
// counters and updates NB_REG offset registers by per-loop strides, with no multipliers
// and no microcode. Each iteration tuple (offsets, indices, wrap flags, last) is pushed
// into a FIFO_DEPTH-deep prefetch FIFO. The FIFO is drained through a valid/ready stream
// port. It sits between the HWPE controller FSM and the streamer address generators.
// PARAMETERS
// NB_LOOPS   3   number of nested loops (>=1); loop 0 is innermost
// NB_REG     4   number of offset registers generated per tuple (>=1)
// REG_WIDTH  32  offset register width
// CNT_WIDTH  16  loop index / range width
// FIFO_DEPTH 4   prefetch FIFO depth (power of 2, >=2)
// PORTS
// clk_i        in   1                            clock
// rst_ni       in   1                            reset, asynchronous, active-low
// test_mode_i  in   1                            test mode (no functional effect)
// clear_i      in   1                            synchronous clear, highest priority
// start_i      in   1                            start pulse; sampled in IDLE only
// range_i      in   NB_LOOPS*CNT_WIDTH           iterations per loop; 0 is treated as 1
// stride_i     in   NB_LOOPS*NB_REG*REG_WIDTH    stride_i[l][r]: added to reg r when loop l steps
// base_i       in   NB_REG*REG_WIDTH             initial offset values
// out_valid_o  out  1                            tuple available at FIFO head
// out_ready_i  in   1                            consumer accepts tuple
// out_offs_o   out  NB_REG*REG_WIDTH             offsets of head tuple
// out_idx_o    out  NB_LOOPS*CNT_WIDTH           loop indices of head tuple
// out_wrap_o   out  NB_LOOPS                     [l]=1: idx[l] changed vs previous tuple
// out_last_o   out  1                            head tuple is the final one
// busy_o       out  1                            state != IDLE
// done_o       out  1                            1-cycle pulse when the final tuple is popped
// BEHAVIOUR
// - Reset or clear_i: state IDLE, FIFO empty, all counters, accumulators and outputs 0.
//   clear_i mid-run aborts without a done_o pulse; it wins over start_i in the same cycle.
// - FSM IDLE->RUN: start_i in IDLE.
//   - Latch range/stride/base into shadow registers; inputs may change afterwards.
//   - Set idx=0 and acc[l][r]=base[r] for all l.
//   - start_i outside IDLE is ignored.
// - RUN: each cycle with FIFO count<FIFO_DEPTH, push tuple {acc[0], idx, wrap, last}, then advance.
//   - k = lowest loop with idx[k]<range[k]-1.
//   - idx[k]++ and acc[k][r]+=stride[k][r].
//   - For j<k: idx[j]=0 and acc[j][r]=new acc[k][r].
//   - wrap of the next tuple: bits 0..k set, others clear.
//   - The first tuple has wrap='0.
// - last=1 when idx[l]==range[l]-1 for all l. Pushing that tuple moves RUN->DRAIN.
// - DRAIN: when the FIFO empties (last popped, done_o=1 that cycle), go to IDLE.
// - Fullness uses the registered count: no push when full even if a pop occurs in the same
//   cycle. Simultaneous push+pop keeps the count unchanged.
// - FIFO output is registered. With start_i at cycle t: RUN at t+1, first push at t+1,
//   out_valid_o at t+2. Steady state sustains 1 tuple/cycle with out_ready_i high.
// - Handshake: transfer on out_valid_o&out_ready_i. Once out_valid_o is asserted, head data
//   stays stable until accepted. out_valid_o does not depend combinationally on out_ready_i.
// - Arithmetic is modulo 2^REG_WIDTH, with signed wrap by two's complement.
//   Total tuples = prod(max(range[l],1)).
// TESTING
// - NB_LOOPS=2, range={3,2}, base0=100, stride[0][0]=4, stride[1][0]=16, ready=1
//   -> offs0 = 100,104,108,116,120,124.
//   -> wrap on tuple 4 is 2'b11; last only on tuple 6; done_o 1 cycle after that pop.
// - Same config, out_ready_i low for 10 cycles after start
//   -> FIFO fills to FIFO_DEPTH, out_valid_o=1 with head data stable (offs0=100).
//   -> Releasing ready yields all 6 tuples in order, none lost or duplicated.
// - range={0,0} -> exactly one tuple, offs=base, last=1, wrap='0; busy_o drops after its pop.
// - clear_i asserted on the 3rd RUN cycle -> next cycle out_valid_o=0, busy_o=0, no done_o.
//   A fresh start then restarts from base.
// - start_i re-pulsed during RUN with different base -> ignored; sequence unchanged.
// - Negative stride: stride[0][0]=-8 (two's complement), base0=4, range0=3 -> offs0 = 4, -4, -12.

Source files
------------

// File: rtl/hwpe_ctrl_uloop_stream.sv
// Nested-loop offset generator for HWPE streamers.
// Walks NB_LOOPS nested counters, keeps one accumulator set per loop level and
// pushes each iteration tuple (offsets, indices, wrap flags, last) into a small
// prefetch FIFO that is drained through a valid/ready stream port.
module hwpe_ctrl_uloop_stream #(
    parameter int unsigned NB_LOOPS   = 3,
    parameter int unsigned NB_REG     = 4,
    parameter int unsigned REG_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                test_mode_i,
    input  logic                                clear_i,
    input  logic                                start_i,
    input  logic [NB_LOOPS*CNT_WIDTH-1:0]       range_i,
    input  logic [NB_LOOPS*NB_REG*REG_WIDTH-1:0] stride_i,
    input  logic [NB_REG*REG_WIDTH-1:0]         base_i,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [NB_REG*REG_WIDTH-1:0]         out_offs_o,
    output logic [NB_LOOPS*CNT_WIDTH-1:0]       out_idx_o,
    output logic [NB_LOOPS-1:0]                 out_wrap_o,
    output logic                                out_last_o,
    output logic                                busy_o,
    output logic                                done_o
);

    localparam int unsigned OFFS_W  = NB_REG * REG_WIDTH;
    localparam int unsigned IDX_W   = NB_LOOPS * CNT_WIDTH;
    localparam int unsigned ENTRY_W = OFFS_W + IDX_W + NB_LOOPS + 1;
    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W   = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // control / loop state
    state_e                 state_q;
    logic                   done_q;
    logic [CNT_WIDTH-1:0]   range_m1_q [NB_LOOPS];
    logic [REG_WIDTH-1:0]   stride_q   [NB_LOOPS][NB_REG];
    logic [REG_WIDTH-1:0]   acc_q      [NB_LOOPS][NB_REG];
    logic [CNT_WIDTH-1:0]   idx_q      [NB_LOOPS];
    logic [NB_LOOPS-1:0]    wrap_q;

    // prefetch FIFO
    logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [CNT_W-1:0]       cnt_q;

    // combinational helpers
    logic                   found_s;
    logic                   last_s;
    logic [NB_LOOPS-1:0]    sel_s;
    logic [NB_LOOPS-1:0]    below_s;
    logic [REG_WIDTH-1:0]   step_acc_s [NB_REG];
    logic [OFFS_W-1:0]      offs_flat_s;
    logic [IDX_W-1:0]       idx_flat_s;
    logic [ENTRY_W-1:0]     entry_s;
    logic [ENTRY_W-1:0]     head_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   unused_test_mode_s;

    assign unused_test_mode_s = test_mode_i;

    // Pick the stepping loop k (one-hot sel_s) and the loops below it that reset.
    always_comb begin
        found_s = 1'b0;
        sel_s   = {NB_LOOPS{1'b0}};
        below_s = {NB_LOOPS{1'b0}};
        for (int l = 0; l < NB_LOOPS; l++) begin
            if (!found_s) begin
                if (idx_q[l] < range_m1_q[l]) begin
                    sel_s[l] = 1'b1;
                    found_s  = 1'b1;
                end else begin
                    below_s[l] = 1'b1;
                end
            end else begin
                below_s[l] = 1'b0;
            end
        end
        last_s = ~found_s;
    end

    // New accumulator value of the stepping loop, shared with all inner loops.
    always_comb begin
        for (int r = 0; r < NB_REG; r++) begin
            step_acc_s[r] = {REG_WIDTH{1'b0}};
            for (int l = 0; l < NB_LOOPS; l++) begin
                if (sel_s[l]) begin
                    step_acc_s[r] = acc_q[l][r] + stride_q[l][r];
                end else begin
                    step_acc_s[r] = step_acc_s[r];
                end
            end
        end
    end

    // Flatten the current tuple into one FIFO entry.
    always_comb begin
        for (int r = 0; r < NB_REG; r++) begin
            offs_flat_s[r*REG_WIDTH +: REG_WIDTH] = acc_q[0][r];
        end
        for (int l = 0; l < NB_LOOPS; l++) begin
            idx_flat_s[l*CNT_WIDTH +: CNT_WIDTH] = idx_q[l];
        end
        entry_s = {last_s, wrap_q, idx_flat_s, offs_flat_s};
    end

    // Fullness is judged on the registered count only, so a same-cycle pop never frees a slot.
    assign push_s      = (state_q == ST_RUN) && (cnt_q != CNT_W'(FIFO_DEPTH));
    assign out_valid_o = (cnt_q != {CNT_W{1'b0}});
    assign pop_s       = out_valid_o & out_ready_i;
    assign head_s      = mem_q[rd_ptr_q];

    assign out_offs_o = head_s[OFFS_W-1:0];
    assign out_idx_o  = head_s[OFFS_W +: IDX_W];
    assign out_wrap_o = head_s[OFFS_W+IDX_W +: NB_LOOPS];
    assign out_last_o = head_s[ENTRY_W-1];
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = done_q;

    // Controller FSM together with the loop counters and accumulators it steers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            wrap_q  <= {NB_LOOPS{1'b0}};
            for (int l = 0; l < NB_LOOPS; l++) begin
                range_m1_q[l] <= {CNT_WIDTH{1'b0}};
                idx_q[l]      <= {CNT_WIDTH{1'b0}};
                for (int r = 0; r < NB_REG; r++) begin
                    stride_q[l][r] <= {REG_WIDTH{1'b0}};
                    acc_q[l][r]    <= {REG_WIDTH{1'b0}};
                end
            end
        end else if (clear_i) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            wrap_q  <= {NB_LOOPS{1'b0}};
            for (int l = 0; l < NB_LOOPS; l++) begin
                range_m1_q[l] <= {CNT_WIDTH{1'b0}};
                idx_q[l]      <= {CNT_WIDTH{1'b0}};
                for (int r = 0; r < NB_REG; r++) begin
                    stride_q[l][r] <= {REG_WIDTH{1'b0}};
                    acc_q[l][r]    <= {REG_WIDTH{1'b0}};
                end
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_RUN;
                        wrap_q  <= {NB_LOOPS{1'b0}};
                        for (int l = 0; l < NB_LOOPS; l++) begin
                            // a zero range behaves like a single iteration
                            if (range_i[l*CNT_WIDTH +: CNT_WIDTH] == {CNT_WIDTH{1'b0}}) begin
                                range_m1_q[l] <= {CNT_WIDTH{1'b0}};
                            end else begin
                                range_m1_q[l] <= range_i[l*CNT_WIDTH +: CNT_WIDTH] - CNT_WIDTH'(1);
                            end
                            idx_q[l] <= {CNT_WIDTH{1'b0}};
                            for (int r = 0; r < NB_REG; r++) begin
                                stride_q[l][r] <= stride_i[(l*NB_REG+r)*REG_WIDTH +: REG_WIDTH];
                                acc_q[l][r]    <= base_i[r*REG_WIDTH +: REG_WIDTH];
                            end
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (push_s && last_s) begin
                        state_q <= ST_DRAIN;
                    end else if (push_s) begin
                        for (int l = 0; l < NB_LOOPS; l++) begin
                            if (sel_s[l]) begin
                                idx_q[l]  <= idx_q[l] + CNT_WIDTH'(1);
                                wrap_q[l] <= 1'b1;
                                for (int r = 0; r < NB_REG; r++) begin
                                    acc_q[l][r] <= step_acc_s[r];
                                end
                            end else if (below_s[l]) begin
                                idx_q[l]  <= {CNT_WIDTH{1'b0}};
                                wrap_q[l] <= 1'b1;
                                for (int r = 0; r < NB_REG; r++) begin
                                    acc_q[l][r] <= step_acc_s[r];
                                end
                            end else begin
                                wrap_q[l] <= 1'b0;
                            end
                        end
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    // the last tuple is always the final FIFO entry
                    if (pop_s && head_s[ENTRY_W-1]) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_DRAIN;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Prefetch FIFO storage, pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {ENTRY_W{1'b0}};
            end
        end else if (clear_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {ENTRY_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= entry_s;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_q <= wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_q <= rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_hwpe_ctrl_uloop_stream.sv
// Self-checking bench for hwpe_ctrl_uloop_stream (2 loops, 2 offset registers).
// A reference model computes every tuple as base + sum(idx*stride) into a queue;
// a monitor pops and compares on every accepted handshake.
module tb_hwpe_ctrl_uloop_stream;

    localparam int NL = 2;
    localparam int NR = 2;
    localparam int RW = 32;
    localparam int CW = 16;
    localparam int FD = 4;

    typedef struct packed {
        logic [NR*RW-1:0] offs;
        logic [NL*CW-1:0] idx;
        logic [NL-1:0]    wrap;
        logic             last;
    } tup_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 test_mode = 1'b0;
    logic                 clear = 1'b0;
    logic                 start = 1'b0;
    logic [NL*CW-1:0]     range_v = '0;
    logic [NL*NR*RW-1:0]  stride_v = '0;
    logic [NR*RW-1:0]     base_v = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [NR*RW-1:0]     out_offs;
    logic [NL*CW-1:0]     out_idx;
    logic [NL-1:0]        out_wrap;
    logic                 out_last;
    logic                 busy;
    logic                 done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_pop_cyc = -10;
    int t_start = 0;
    tup_t sb_q[$];

    int          rng [NL];
    logic [31:0] strd [NL][NR];
    logic [31:0] bse [NR];

    hwpe_ctrl_uloop_stream #(
        .NB_LOOPS(NL), .NB_REG(NR), .REG_WIDTH(RW), .CNT_WIDTH(CW), .FIFO_DEPTH(FD)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .test_mode_i(test_mode), .clear_i(clear),
        .start_i(start), .range_i(range_v), .stride_i(stride_v), .base_i(base_v),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_offs_o(out_offs),
        .out_idx_o(out_idx), .out_wrap_o(out_wrap), .out_last_o(out_last),
        .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: compare every accepted tuple, and time the done pulse.
    always @(negedge clk) begin
        tup_t e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_tuple: got offs=%h idx=%h, expected no tuple", out_offs, out_idx);
                end else begin
                    e = sb_q.pop_front();
                    if ({out_offs, out_idx, out_wrap, out_last} !== {e.offs, e.idx, e.wrap, e.last}) begin
                        failures++;
                        $display("FAIL tuple: got offs=%h idx=%h wrap=%b last=%b, expected offs=%h idx=%h wrap=%b last=%b",
                                 out_offs, out_idx, out_wrap, out_last, e.offs, e.idx, e.wrap, e.last);
                    end
                    if (e.last) last_pop_cyc = cyc;
                end
            end
            if (done) begin
                done_cnt++;
                checks++;
                if (cyc != last_pop_cyc + 1 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL done_timing: got done at cycle %0d busy=%b, expected cycle %0d busy=0",
                             cyc, busy, last_pop_cyc + 1);
                end
            end
        end
    end

    task automatic set_cfg(input int r0, input int r1, input logic [31:0] b0, input logic [31:0] b1,
                           input logic [31:0] s00, input logic [31:0] s01,
                           input logic [31:0] s10, input logic [31:0] s11);
        rng[0] = r0; rng[1] = r1;
        bse[0] = b0; bse[1] = b1;
        strd[0][0] = s00; strd[0][1] = s01; strd[1][0] = s10; strd[1][1] = s11;
        range_v  = {16'(r1), 16'(r0)};
        base_v   = {b1, b0};
        stride_v = {s11, s10, s01, s00};
    endtask

    // Reference model: offsets by multiplication, wrap from the highest changed index.
    task automatic sb_model();
        int n0, n1;
        tup_t t;
        n0 = (rng[0] == 0) ? 1 : rng[0];
        n1 = (rng[1] == 0) ? 1 : rng[1];
        for (int i1 = 0; i1 < n1; i1++) begin
            for (int i0 = 0; i0 < n0; i0++) begin
                for (int r = 0; r < NR; r++)
                    t.offs[r*RW +: RW] = bse[r] + 32'(i0) * strd[0][r] + 32'(i1) * strd[1][r];
                t.idx = {16'(i1), 16'(i0)};
                if (i0 == 0 && i1 == 0) t.wrap = 2'b00;
                else if (i0 == 0)       t.wrap = 2'b11;
                else                    t.wrap = 2'b01;
                t.last = (i0 == n0 - 1) && (i1 == n1 - 1);
                sb_q.push_back(t);
            end
        end
    endtask

    task automatic do_start();
        @(posedge clk); #1;
        start = 1'b1;
        sb_model();
        t_start = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int d0;
        d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, busy, done, out_offs, out_idx, out_wrap, out_last} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b busy=%b done=%b offs=%h idx=%h wrap=%b last=%b, expected all 0",
                     out_valid, busy, done, out_offs, out_idx, out_wrap, out_last);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bit ok;
        set_cfg(3, 2, 32'd100, 32'd7, 32'd4, 32'd1, 32'd16, 32'd10);
        out_ready = 1'b1;
        do_start();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_latency1: got valid=%b busy=%b, expected valid=0 busy=1", out_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_offs[31:0] !== 32'd100) begin
            failures++;
            $display("FAIL basic_latency2: got valid=%b offs0=%0d, expected valid=1 offs0=100", out_valid, out_offs[31:0]);
        end
        wait_done(50, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL basic_done: got no done within 50 cycles, expected done"); end
        checks++;
        if (sb_q.size() != 0) begin failures++; $display("FAIL basic_count: got %0d tuples missing, expected 0", sb_q.size()); end
        checks++;
        if (last_pop_cyc != t_start + 7) begin
            failures++;
            $display("FAIL basic_throughput: got last pop at cycle %0d, expected %0d", last_pop_cyc, t_start + 7);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        set_cfg(3, 2, 32'd100, 32'd0, 32'd4, 32'd2, 32'd16, 32'd3);
        out_ready = 1'b0;
        do_start();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 1) begin
                checks++;
                if (out_valid !== 1'b1 || out_offs[31:0] !== 32'd100 || out_last !== 1'b0 || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_hold: got valid=%b offs0=%0d last=%b busy=%b, expected 1/100/0/1",
                             out_valid, out_offs[31:0], out_last, busy);
                end
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done(50, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL stall_done: got no done within 50 cycles, expected done"); end
        checks++;
        if (sb_q.size() != 0) begin failures++; $display("FAIL stall_count: got %0d tuples missing, expected 0", sb_q.size()); end
    endtask

    task automatic test_zero_range();
        bit ok;
        set_cfg(0, 0, 32'd55, 32'd66, 32'd4, 32'd4, 32'd16, 32'd16);
        out_ready = 1'b0;
        do_start();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_offs !== {32'd66, 32'd55} || out_last !== 1'b1 || out_wrap !== 2'b00) begin
            failures++;
            $display("FAIL zero_head: got valid=%b offs=%h last=%b wrap=%b, expected 1/%h/1/00",
                     out_valid, out_offs, out_last, out_wrap, {32'd66, 32'd55});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done(20, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL zero_done: got no done within 20 cycles, expected done"); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL zero_idle: got busy=%b valid=%b, expected 0/0", busy, out_valid);
        end
    endtask

    task automatic test_clear();
        bit ok;
        int d0;
        set_cfg(3, 2, 32'd100, 32'd5, 32'd4, 32'd1, 32'd16, 32'd2);
        out_ready = 1'b0;
        d0 = done_cnt;
        do_start();
        @(posedge clk); #1;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL clear_abort: got valid=%b busy=%b done=%b, expected 0/0/0", out_valid, busy, done);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt != d0) begin failures++; $display("FAIL clear_no_done: got %0d done pulses, expected 0", done_cnt - d0); end
        sb_q.delete();
        out_ready = 1'b1;
        do_start();
        wait_done(50, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL clear_restart: got no done within 50 cycles, expected done"); end
        checks++;
        if (sb_q.size() != 0) begin failures++; $display("FAIL clear_count: got %0d tuples missing, expected 0", sb_q.size()); end
    endtask

    task automatic test_restart_ignored();
        bit ok;
        set_cfg(3, 2, 32'd100, 32'd9, 32'd4, 32'd1, 32'd16, 32'd8);
        out_ready = 1'b1;
        do_start();
        @(posedge clk); #1;
        base_v  = {32'd900, 32'd500};
        range_v = {16'd4, 16'd4};
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(50, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL restart_done: got no done within 50 cycles, expected done"); end
        checks++;
        if (sb_q.size() != 0) begin failures++; $display("FAIL restart_count: got %0d tuples missing, expected 0", sb_q.size()); end
    endtask

    task automatic test_neg_stride();
        bit ok;
        set_cfg(3, 1, 32'd4, 32'd0, 32'hFFFF_FFF8, 32'd3, 32'd0, 32'd0);
        out_ready = 1'b1;
        do_start();
        wait_done(30, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL neg_done: got no done within 30 cycles, expected done"); end
        checks++;
        if (sb_q.size() != 0) begin failures++; $display("FAIL neg_count: got %0d tuples missing, expected 0", sb_q.size()); end
    endtask

    task automatic test_random();
        bit ok;
        for (int n = 0; n < 6; n++) begin
            set_cfg($urandom_range(0, 4), $urandom_range(0, 3), $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom);
            out_ready = 1'b0;
            do_start();
            ok = 1'b0;
            for (int i = 0; i < 200 && !ok; i++) begin
                @(posedge clk); #1;
                out_ready = 1'($urandom_range(0, 1));
                if (!busy && sb_q.size() == 0) ok = 1'b1;
            end
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL random_run%0d: got busy=%b with %0d tuples pending, expected idle and 0", n, busy, sb_q.size());
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_range();
        test_clear();
        test_restart_ignored();
        test_neg_stride();
        test_random();
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
